// File: rtl/breath_led_ctrl.sv
// Breathing LED driver: a PWM whose duty ramps linearly down then up, forever.
// Three cascaded counters (tick, PWM period, ramp step) plus a direction flag; led is active-low.
module breath_led_ctrl #(
  parameter logic [6:0] CNT_2US_MAX = 7'd100,
  parameter logic [9:0] CNT_2MS_MAX = 10'd1000,
  parameter logic [9:0] CNT_2S_MAX  = 10'd1000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  output logic led
);

  logic [6:0] r_cnt_2us;
  logic [9:0] r_cnt_2ms;
  logic [9:0] r_cnt_2s;
  logic       r_cnt_en;
  logic       r_led;

  logic w_tick;
  logic w_pwm_end;
  logic w_ramp_end;
  logic w_led_on;

  assign w_tick     = (r_cnt_2us == CNT_2US_MAX - 7'd1);
  assign w_pwm_end  = w_tick && (r_cnt_2ms == CNT_2MS_MAX - 10'd1);
  assign w_ramp_end = w_pwm_end && (r_cnt_2s == CNT_2S_MAX - 10'd1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)  r_cnt_2us <= '0;
    else if (w_tick) r_cnt_2us <= '0;
    else             r_cnt_2us <= r_cnt_2us + 7'd1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)     r_cnt_2ms <= '0;
    else if (w_pwm_end) r_cnt_2ms <= '0;
    else if (w_tick)    r_cnt_2ms <= r_cnt_2ms + 10'd1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)      r_cnt_2s <= '0;
    else if (w_ramp_end) r_cnt_2s <= '0;
    else if (w_pwm_end)  r_cnt_2s <= r_cnt_2s + 10'd1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)      r_cnt_en <= 1'b0;
    else if (w_ramp_end) r_cnt_en <= ~r_cnt_en;
  end

  // Dimming lights the tail of each period, brightening the head, so duty steps by one tick per period.
  assign w_led_on = r_cnt_en ? (r_cnt_2ms < r_cnt_2s) : (r_cnt_2ms > r_cnt_2s);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_led <= 1'b1;
    else            r_led <= ~w_led_on;
  end

  assign led = r_led;

endmodule

// File: tb/tb_breath_led_ctrl.sv
// Self-checking bench: shrunk-parameter DUT checked window-by-window against closed-form duty,
// plus a default-parameter DUT for a short timing check.
module tb_breath_led_ctrl;

  logic sys_clk;
  logic sys_rst_n;
  logic rst_def_n;
  logic led;
  logic led_def;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int exp_q[$];

  breath_led_ctrl #(
    .CNT_2US_MAX(7'd1),
    .CNT_2MS_MAX(10'd10),
    .CNT_2S_MAX (10'd10)
  ) u_dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .led      (led)
  );

  breath_led_ctrl u_def (
    .sys_clk  (sys_clk),
    .sys_rst_n(rst_def_n),
    .led      (led_def)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish (actual=timeout required=finish)");
    $fatal(1);
  end

  // Lit clocks in PWM window p after reset, from the duty formula (10-clock windows, 20-window breath).
  function automatic int duty(input int p);
    int k;
    int en;
    k  = p % 10;
    en = (p / 10) % 2;
    return en ? k : 9 - k;
  endfunction

  task automatic release_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic run_windows(input int nwin, input string tag);
    int lit;
    int exp;
    for (int p = 0; p < nwin; p++) exp_q.push_back(duty(p));
    for (int p = 0; p < nwin; p++) begin
      lit = 0;
      for (int i = 0; i < 10; i++) begin
        @(posedge sys_clk);
        @(negedge sys_clk);
        if (led === 1'b0) lit++;
      end
      exp = exp_q.pop_front();
      chk_cnt++;
      if (lit !== exp)
        $display("FAIL %s window %0d lit clocks: actual=%0d required=%0d", tag, p, lit, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    #200;
    chk_cnt++;
    if (led !== 1'b1) $display("FAIL reset_hold led: actual=%b required=1", led);
    else pass_cnt++;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk_cnt++;
    if (led !== 1'b1) $display("FAIL first_edge led: actual=%b required=1", led);
    else pass_cnt++;
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk_cnt++;
    if (led !== 1'b0) $display("FAIL second_edge led: actual=%b required=0", led);
    else pass_cnt++;
  endtask

  task automatic test_breath();
    release_reset();
    run_windows(40, "breath");
    chk_cnt++;
    if (u_dut.r_cnt_2us !== 7'd0)
      $display("FAIL tick_always cnt_2us: actual=%0d required=0", u_dut.r_cnt_2us);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    // 152 edges in: window 15 (brightening, k=5), cnt_2ms was 1 -> lit.
    repeat (152) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
    end
    chk_cnt++;
    if (led !== 1'b0) $display("FAIL pre_reset led: actual=%b required=0", led);
    else pass_cnt++;
    #3 sys_rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (led !== 1'b1) $display("FAIL async_reset led: actual=%b required=1", led);
    else pass_cnt++;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    run_windows(20, "after_reset");
  endtask

  task automatic test_default_params();
    @(negedge sys_clk);
    rst_def_n = 1'b1;
    for (int n = 1; n <= 201; n++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      if (n == 100) begin
        chk_cnt++;
        if (led_def !== 1'b1) $display("FAIL def_edge100 led: actual=%b required=1", led_def);
        else pass_cnt++;
      end
      if (n == 101) begin
        chk_cnt++;
        if (led_def !== 1'b0) $display("FAIL def_edge101 led: actual=%b required=0", led_def);
        else pass_cnt++;
      end
      if (n == 150) begin
        chk_cnt++;
        if (u_def.r_cnt_2us !== 7'd50)
          $display("FAIL def_cnt_2us: actual=%0d required=50", u_def.r_cnt_2us);
        else pass_cnt++;
      end
      if (n == 199) begin
        chk_cnt++;
        if (u_def.r_cnt_2ms !== 10'd1)
          $display("FAIL def_cnt_2ms_199: actual=%0d required=1", u_def.r_cnt_2ms);
        else pass_cnt++;
      end
      if (n == 200) begin
        chk_cnt++;
        if (u_def.r_cnt_2ms !== 10'd2)
          $display("FAIL def_cnt_2ms_200: actual=%0d required=2", u_def.r_cnt_2ms);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    rst_def_n = 1'b0;
    test_reset();
    test_breath();
    test_async_reset();
    test_default_params();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/breath_led_ctrl.md
# breath_led_ctrl

Single-channel "breathing" LED driver: a PWM whose duty cycle ramps linearly from maximum to minimum brightness and back, forever, with no external control. Three cascaded counters set the timing: a 2 µs tick, a 2 ms PWM period, and a 2 s ramp. A direction flag flips the ramp at the end of each 2 s half-cycle. The block sits directly between the board clock/reset and an active-low LED pin. All timing constants are parameters so simulation can shrink them.

## Interface
- CNT_2US_MAX, 7-bit, default 100 — clocks per tick (50 MHz × 2 µs); must be ≥ 1.
- CNT_2MS_MAX, 10-bit, default 1000 — ticks per PWM period (2 ms); must be ≥ 1.
- CNT_2S_MAX, 10-bit, default 1000 — PWM periods per ramp half-cycle (2 s); must be ≥ 1.
- sys_clk  input  1  system clock, 50 MHz nominal, rising-edge.
- sys_rst_n  input  1  reset, asynchronous, active-low.
- led  output  1  LED drive, active-low (0 = lit), registered.

## Operation
- cnt_2us (7 bits):
  - resets to 0;
  - returns to 0 when equal to CNT_2US_MAX-1, else increments every clock;
  - tick = (cnt_2us == CNT_2US_MAX-1).
- cnt_2ms (10 bits):
  - resets to 0;
  - on tick, returns to 0 if equal to CNT_2MS_MAX-1, else increments;
  - holds otherwise;
  - pwm_end = tick && (cnt_2ms == CNT_2MS_MAX-1).
- cnt_2s (10 bits):
  - resets to 0;
  - on pwm_end, returns to 0 if equal to CNT_2S_MAX-1, else increments;
  - holds otherwise;
  - ramp_end = pwm_end && (cnt_2s == CNT_2S_MAX-1).
- cnt_en (direction flag):
  - resets to 0;
  - toggles on ramp_end, holds otherwise.
- led (register):
  - resets to 1 (dark);
  - each clock, next value = 0 if (cnt_en==1 && cnt_2ms < cnt_2s) or (cnt_en==0 && cnt_2ms > cnt_2s), else 1;
  - comparisons are unsigned and use the current (pre-update) register values.
- Duty per PWM period, in ticks lit, as a function of cnt_2s = k:
  - cnt_en=0 (dimming): CNT_2MS_MAX-1-k;
  - cnt_en=1 (brightening): k.
- With CNT_2US_MAX = 1, tick is constantly 1: cnt_2ms advances every clock and cnt_2us stays 0.

## Timing
- Fully synchronous to rising sys_clk; asynchronous clear of all registers on sys_rst_n low, taking effect immediately.
- First rising edge after reset release: cnt_2us=0, cnt_2ms=0, cnt_2s=0, cnt_en=0, so led stays 1.
- led lags the counter values by one clock (registered compare).
- Default periods:
  - PWM period = CNT_2US_MAX × CNT_2MS_MAX clocks = 100 000 (2 ms);
  - half-cycle = × CNT_2S_MAX = 10^8 clocks (2 s);
  - full breath = 4 s.
- Wrap-around: cnt_2ms, cnt_2s and the cnt_en toggle all update on the same clock as the final tick, so there are no idle cycles between periods.
- Reset asserted mid-ramp: led returns to 1 and the ramp restarts from the dimming phase with cnt_2s=0.

## Test plan
- Reset held 200 ns, then released, with CNT_2US_MAX=1, CNT_2MS_MAX=10, CNT_2S_MAX=10 and a 20 ns clock:
  - led=1 during reset;
  - led=1 at the first edge after release;
  - led=0 at the second edge.
- Same parameters, first PWM window (cnt_en=0, cnt_2s=0): led low for 9 of 10 clocks.
- Same parameters, dimming ramp: lit clocks per 10-clock window go 9,8,…,0 for cnt_2s = 0..9.
- Same parameters, after 100 clocks: cnt_en=1; lit clocks per window go 0,1,…,9. After 200 clocks: cnt_en=0 again and the pattern repeats (full period 200 clocks).
- Pulse sys_rst_n low asynchronously (between clock edges) mid-ramp:
  - led goes to 1 without waiting for a clock;
  - after release, the sequence matches the post-reset sequence exactly.
- Default parameters, short run: cnt_2ms increments once every 100 clocks, and the first PWM period lasts 100 000 clocks.
